mem_arbiter: RTL

//   Shares the single unified main-memory port between the I-cache and D-cache

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one main-memory port between the I-cache and D-cache
//             miss/writeback paths. One transaction in flight at a time,
//             D-side priority with a starvation guard for the I-side, and a
//             WAIT-state timeout that aborts a stuck transaction.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic       c_ownerI    = 1'b0;
  localparam logic       c_ownerD    = 1'b1;
  localparam logic [3:0] c_starveMax = 4'(STARVE_MAX);
  // The abort decision is taken in the WAIT cycle that is TIMEOUT-1 cycles
  // after the command strobe, so err lands exactly TIMEOUT cycles after mem_en.
  localparam logic [7:0] c_abortCnt  = 8'(TIMEOUT - 2);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_owner;
  logic                r_memWr;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memWdata;
  logic [DATA_W-1:0]   r_iRdata;
  logic [DATA_W-1:0]   r_dRdata;
  logic [7:0]          r_waitCnt;
  logic [3:0]          r_starveCnt;
  logic                r_err;

  logic                w_anyReq;
  logic                w_grantI;
  logic                w_abort;

  // D has priority unless the I-side has already been passed over STARVE_MAX times
  assign w_anyReq = i_req | d_req;
  assign w_grantI = i_req & (~d_req | (r_starveCnt == c_starveMax));
  assign w_abort  = (r_state == S_WAIT) & ~mem_done & (r_waitCnt == c_abortCnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP loop
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_anyReq) w_nextState = S_ISSUE;
      S_ISSUE: w_nextState = S_WAIT;
      S_WAIT: begin
        if (mem_done) begin
          w_nextState = S_RESP;
        end else if (w_abort) begin
          w_nextState = S_IDLE;
        end
      end
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Pick the owner and latch its command; held unchanged until back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= c_ownerI;
      r_memWr    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else if ((r_state == S_IDLE) && w_anyReq) begin
      r_owner    <= w_grantI ? c_ownerI : c_ownerD;
      r_memWr    <= w_grantI ? 1'b0 : d_wr;
      r_memAddr  <= w_grantI ? i_addr : d_addr;
      r_memWdata <= w_grantI ? '0 : d_wdata;
    end
  end

  // Count consecutive D grants made while the I-side was waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (!i_req || w_grantI) begin
        r_starveCnt <= '0;
      end else if (r_starveCnt != c_starveMax) begin
        r_starveCnt <= r_starveCnt + 4'd1;
      end
    end
  end

  // Cycles spent in WAIT; restarts from zero on every new transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end else begin
      r_waitCnt <= '0;
    end
  end

  // Capture memory read data into the owner's return register on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iRdata <= '0;
      r_dRdata <= '0;
    end else if ((r_state == S_WAIT) && mem_done) begin
      if (r_owner == c_ownerI) begin
        r_iRdata <= mem_rdata;
      end else begin
        r_dRdata <= mem_rdata;
      end
    end
  end

  // One-cycle abort pulse in the cycle after the timeout decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
    end
  end

  assign mem_en    = (r_state == S_ISSUE);
  assign mem_wr    = r_memWr;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign i_done    = (r_state == S_RESP) & (r_owner == c_ownerI);
  assign d_done    = (r_state == S_RESP) & (r_owner == c_ownerD);
  assign i_rdata   = r_iRdata;
  assign d_rdata   = r_dRdata;
  assign err       = r_err;

endmodule
`default_nettype wire
